// File: rtl/mul8_share_sched.sv
// -----------------------------------------------------------------------------
// mul8_share_sched
//
// Purpose:
//   Shares one W x W multiplier datapath (partial products + GPC compressor
//   tree, external to this block) among NREQ requesters. A round-robin arbiter
//   issues at most one operation per cycle, the issued operands are registered
//   towards the datapath, a LAT-deep tracker follows each operation through the
//   datapath, and the returning product is parked in a per-requester response
//   slot until that requester takes it.
//
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   req_valid_i  [NREQ]        requester i has operands
//   req_ready_o  [NREQ]        one-hot grant (or zero) this cycle
//   req_a_i      [NREQ*W]      operand A, requester i at [i*W +: W]
//   req_b_i      [NREQ*W]      operand B, same packing
//   dp_a_o       [W]           registered operand A to the datapath
//   dp_b_o       [W]           registered operand B to the datapath
//   dp_valid_o                 dp_a_o/dp_b_o carry a new operation
//   dp_p_i       [2W]          datapath product, LAT cycles after dp_valid_o
//   rsp_valid_o  [NREQ]        slot i holds a result
//   rsp_ready_i  [NREQ]        requester i takes its result
//   rsp_p_o      [NREQ*2W]     held product, slot i at [i*2W +: 2W]
//   busy_o                     any slot occupied or an issue on the datapath
//
// Slot FSM (one per requester):
//   state      | meaning
//   S_IDLE     | no operation outstanding, requester may be granted
//   S_INFLIGHT | operands issued, product still travelling through the datapath
//   S_HOLD     | product captured, rsp_valid_o high until the handshake
// -----------------------------------------------------------------------------
module mul8_share_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*W-1:0]     req_a_i,
  input  logic [NREQ*W-1:0]     req_b_i,
  output logic [W-1:0]          dp_a_o,
  output logic [W-1:0]          dp_b_o,
  output logic                  dp_valid_o,
  input  logic [2*W-1:0]        dp_p_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  input  logic [NREQ-1:0]       rsp_ready_i,
  output logic [NREQ*2*W-1:0]   rsp_p_o,
  output logic                  busy_o
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_INFLIGHT = 2'd1,
    S_HOLD     = 2'd2
  } slot_e;

  // slot state and registered response outputs
  slot_e            slot_q      [NREQ];
  logic [NREQ-1:0]  rsp_valid_q;
  logic [2*W-1:0]   rsp_p_q     [NREQ];

  // issue stage
  logic [IDW-1:0]   ptr_q;
  logic             dp_valid_q;
  logic [W-1:0]     dp_a_q;
  logic [W-1:0]     dp_b_q;
  logic [IDW-1:0]   dp_id_q;

  // in-flight tracker, fed from the issue register so its last stage lines up
  // with dp_p_i exactly LAT cycles after dp_valid_o
  logic             trk_vld_q   [LAT];
  logic [IDW-1:0]   trk_id_q    [LAT];

  logic [NREQ-1:0]  elig;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_id;
  logic [W-1:0]     gnt_a;
  logic [W-1:0]     gnt_b;
  logic [IDW-1:0]   ptr_d;
  logic             trk_out_vld;
  logic [IDW-1:0]   trk_out_id;

  // Eligibility looks only at the registered slot state, so a slot released
  // this cycle is not granted again until the next one.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid_i[i] && (slot_q[i] == S_IDLE);
    end
  end

  // Round-robin search starting at ptr_q. The index is kept one bit wider so
  // the wrap works for any NREQ, not just powers of two.
  always_comb begin
    logic [IDW:0] idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(off);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end
      if (!gnt_vld && elig[idx[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    gnt_a       = '0;
    gnt_b       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vld && (gnt_id == IDW'(i))) begin
        req_ready_o[i] = 1'b1;
        gnt_a          = req_a_i[i*W +: W];
        gnt_b          = req_b_i[i*W +: W];
      end
    end
  end

  assign ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;

  // Issue register: operands hold their last value when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      dp_id_q    <= '0;
    end else begin
      dp_valid_q <= gnt_vld;
      if (gnt_vld) begin
        ptr_q   <= ptr_d;
        dp_a_q  <= gnt_a;
        dp_b_q  <= gnt_b;
        dp_id_q <= gnt_id;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < LAT; i++) begin
        trk_vld_q[i] <= 1'b0;
        trk_id_q[i]  <= '0;
      end
    end else begin
      trk_vld_q[0] <= dp_valid_q;
      trk_id_q[0]  <= dp_id_q;
      for (int i = 1; i < LAT; i++) begin
        trk_vld_q[i] <= trk_vld_q[i-1];
        trk_id_q[i]  <= trk_id_q[i-1];
      end
    end
  end

  assign trk_out_vld = trk_vld_q[LAT-1];
  assign trk_out_id  = trk_id_q[LAT-1];

  // Slot FSMs. Capture only ever hits an INFLIGHT slot because a slot is not
  // re-granted until it has gone back to IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_valid_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_q[i]  <= S_IDLE;
        rsp_p_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case (slot_q[i])
          S_IDLE: begin
            if (gnt_vld && (gnt_id == IDW'(i))) begin
              slot_q[i] <= S_INFLIGHT;
            end
          end
          S_INFLIGHT: begin
            if (trk_out_vld && (trk_out_id == IDW'(i))) begin
              slot_q[i]      <= S_HOLD;
              rsp_p_q[i]     <= dp_p_i;
              rsp_valid_q[i] <= 1'b1;
            end
          end
          S_HOLD: begin
            if (rsp_ready_i[i]) begin
              slot_q[i]      <= S_IDLE;
              rsp_valid_q[i] <= 1'b0;
            end
          end
          default: begin
            slot_q[i]      <= S_IDLE;
            rsp_valid_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dp_a_o      = dp_a_q;
  assign dp_b_o      = dp_b_q;
  assign dp_valid_o  = dp_valid_q;
  assign rsp_valid_o = rsp_valid_q;

  always_comb begin
    rsp_p_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_p_o[i*2*W +: 2*W] = rsp_p_q[i];
    end
  end

  always_comb begin
    busy_o = dp_valid_q;
    for (int i = 0; i < NREQ; i++) begin
      if (slot_q[i] != S_IDLE) begin
        busy_o = 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // A tracker hit on a slot that is not waiting for a product means the
  // datapath latency does not match LAT or the slot bookkeeping is broken.
  always @(posedge clk_i) begin
    if (rst_n_i && trk_out_vld) begin
      assert (slot_q[trk_out_id] == S_INFLIGHT)
        else $error("mul8_share_sched: product returned for slot %0d which is not in flight", trk_out_id);
    end
  end
`endif

endmodule

// File: tb/tb_mul8_share_sched.sv
module tb_mul8_share_sched;

  localparam int NR = 4;
  localparam int NI = 3;   // instances with LAT = 2, 1, 8

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   req_valid [NI];
  logic [NR-1:0]   req_ready [NI];
  logic [NR*8-1:0] req_a     [NI];
  logic [NR*8-1:0] req_b     [NI];
  logic [7:0]      dp_a      [NI];
  logic [7:0]      dp_b      [NI];
  logic            dp_valid  [NI];
  logic [15:0]     dp_p      [NI];
  logic [NR-1:0]   rsp_valid [NI];
  logic [NR-1:0]   rsp_ready [NI];
  logic [NR*16-1:0] rsp_p    [NI];
  logic            busy      [NI];

  function automatic int lat_of(input int n);
    return (n == 0) ? 2 : ((n == 1) ? 1 : 8);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
    logic [15:0] pp [L];
    logic        pv [L];
    logic [15:0] junk;

    mul8_share_sched #(.NREQ(NR), .W(8), .LAT(L)) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_a_i     (req_a[g]),
      .req_b_i     (req_b[g]),
      .dp_a_o      (dp_a[g]),
      .dp_b_o      (dp_b[g]),
      .dp_valid_o  (dp_valid[g]),
      .dp_p_i      (dp_p[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_ready_i (rsp_ready[g]),
      .rsp_p_o     (rsp_p[g]),
      .busy_o      (busy[g])
    );

    // behavioural datapath: product appears exactly L cycles after dp_valid,
    // random junk on every other cycle
    always @(posedge clk) begin
      junk  <= 16'($urandom);
      pp[0] <= 16'(dp_a[g]) * 16'(dp_b[g]);
      pv[0] <= dp_valid[g];
      for (int i = 1; i < L; i++) begin
        pp[i] <= pp[i-1];
        pv[i] <= pv[i-1];
      end
    end
    assign dp_p[g] = (pv[L-1] === 1'b1) ? pp[L-1] : junk;
  end

  // ---------------- reference model (transaction level) ----------------
  bit          m_out  [NI][NR];   // requester has an operation outstanding
  int          m_rdy  [NI][NR];   // cycle its result becomes visible
  logic [15:0] m_prod [NI][NR];
  int          m_ptr  [NI];
  bit          m_dpv  [NI];
  logic [7:0]  m_dpa  [NI];
  logic [7:0]  m_dpb  [NI];
  int          m_gnt  [NI];
  logic [NR-1:0] e_rdy  [NI];
  logic [NR-1:0] e_rspv [NI];
  bit          e_busy [NI];
  int          cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic model_clear();
    for (int n = 0; n < NI; n++) begin
      for (int i = 0; i < NR; i++) begin
        m_out[n][i] = 1'b0; m_rdy[n][i] = 0; m_prod[n][i] = '0;
      end
      m_ptr[n] = 0; m_dpv[n] = 1'b0; m_dpa[n] = '0; m_dpb[n] = '0;
    end
  endtask

  task automatic model_eval(input int n);
    e_rspv[n] = '0;
    for (int i = 0; i < NR; i++)
      if (m_out[n][i] && cyc >= m_rdy[n][i]) e_rspv[n][i] = 1'b1;
    m_gnt[n] = -1;
    for (int off = 0; off < NR; off++) begin
      int idx;
      idx = (m_ptr[n] + off) % NR;
      if (m_gnt[n] < 0 && req_valid[n][idx] && !m_out[n][idx]) m_gnt[n] = idx;
    end
    e_rdy[n] = (m_gnt[n] >= 0) ? 4'(1 << m_gnt[n]) : 4'b0;
    e_busy[n] = m_dpv[n];
    for (int i = 0; i < NR; i++) if (m_out[n][i]) e_busy[n] = 1'b1;
  endtask

  task automatic model_adv(input int n);
    int k;
    for (int i = 0; i < NR; i++)
      if (e_rspv[n][i] && rsp_ready[n][i]) m_out[n][i] = 1'b0;
    k = m_gnt[n];
    if (k >= 0) begin
      m_out[n][k]  = 1'b1;
      m_rdy[n][k]  = cyc + lat_of(n) + 2;
      m_prod[n][k] = 16'(req_a[n][k*8 +: 8]) * 16'(req_b[n][k*8 +: 8]);
      m_dpa[n]     = req_a[n][k*8 +: 8];
      m_dpb[n]     = req_b[n][k*8 +: 8];
      m_ptr[n]     = (k + 1) % NR;
      m_dpv[n]     = 1'b1;
    end else begin
      m_dpv[n] = 1'b0;
    end
  endtask

  task automatic eval_all();
    for (int n = 0; n < NI; n++) model_eval(n);
  endtask

  task automatic tick();
    eval_all();
    for (int n = 0; n < NI; n++) model_adv(n);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    for (int n = 0; n < NI; n++) begin
      req_valid[n] = '0; rsp_ready[n] = '0; req_a[n] = '0; req_b[n] = '0;
    end
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int n = 0; n < NI; n++) begin
      req_valid[n] = '0; rsp_ready[n] = '0; req_a[n] = '0; req_b[n] = '0;
    end
    rst_n = 1'b0;
    #3;
    for (int n = 0; n < NI; n++) begin
      n_tests++;
      if ({dp_valid[n], dp_a[n], dp_b[n], rsp_valid[n], busy[n], req_ready[n]} !== 26'd0 || rsp_p[n] !== 64'd0) begin
        n_fail++;
        $display("FAIL reset n=%0d got dpv=%b a=%h b=%h rspv=%b busy=%b rsp_p=%h, want all zero",
                 n, dp_valid[n], dp_a[n], dp_b[n], rsp_valid[n], busy[n], rsp_p[n]);
      end
    end
    do_reset();
  endtask

  task automatic test_single(input int n);
    int lat = lat_of(n);
    do_reset();
    for (int c = 0; c <= lat + 4; c++) begin
      req_a[n] = $urandom; req_b[n] = $urandom;
      req_a[n][7:0] = 8'hFF; req_b[n][7:0] = 8'hFF;
      req_valid[n] = (c == 0) ? 4'b0001 : 4'b0000;
      rsp_ready[n] = 4'b0001;
      eval_all();
      @(negedge clk);
      n_tests++;
      if ({req_ready[n], rsp_valid[n], dp_valid[n], busy[n]} !== {e_rdy[n], e_rspv[n], m_dpv[n], e_busy[n]}) begin
        n_fail++;
        $display("FAIL single_ctl n=%0d c=%0d got rdy=%b rspv=%b dpv=%b busy=%b want %b %b %b %b", n, c,
                 req_ready[n], rsp_valid[n], dp_valid[n], busy[n], e_rdy[n], e_rspv[n], m_dpv[n], e_busy[n]);
      end
      if (c == 0) begin
        n_tests++;
        if (req_ready[n] !== 4'b0001) begin
          n_fail++; $display("FAIL single_grant n=%0d got %b want 0001", n, req_ready[n]);
        end
      end
      if (c == 1) begin
        n_tests++;
        if (dp_valid[n] !== 1'b1 || dp_a[n] !== 8'hFF || dp_b[n] !== 8'hFF) begin
          n_fail++; $display("FAIL single_issue n=%0d got v=%b a=%h b=%h want 1 ff ff", n, dp_valid[n], dp_a[n], dp_b[n]);
        end
      end
      if (c == lat + 2) begin
        n_tests++;
        if (rsp_valid[n][0] !== 1'b1 || rsp_p[n][15:0] !== 16'hFE01) begin
          n_fail++; $display("FAIL single_rsp n=%0d got v=%b p=%h want 1 fe01", n, rsp_valid[n][0], rsp_p[n][15:0]);
        end
      end
      if (c == lat + 3) begin
        n_tests++;
        if (rsp_valid[n] !== 4'b0 || busy[n] !== 1'b0) begin
          n_fail++; $display("FAIL single_idle n=%0d got rspv=%b busy=%b want 0 0", n, rsp_valid[n], busy[n]);
        end
      end
      tick();
    end
  endtask

  task automatic test_rr(input int n);
    int gl[$];
    do_reset();
    for (int c = 0; c < 40; c++) begin
      req_valid[n] = 4'b1111; rsp_ready[n] = 4'b1111;
      req_a[n] = $urandom; req_b[n] = $urandom;
      eval_all();
      @(negedge clk);
      n_tests++;
      if ({req_ready[n], rsp_valid[n], dp_valid[n], busy[n]} !== {e_rdy[n], e_rspv[n], m_dpv[n], e_busy[n]}) begin
        n_fail++;
        $display("FAIL rr_ctl n=%0d c=%0d got rdy=%b rspv=%b dpv=%b busy=%b want %b %b %b %b", n, c,
                 req_ready[n], rsp_valid[n], dp_valid[n], busy[n], e_rdy[n], e_rspv[n], m_dpv[n], e_busy[n]);
      end
      for (int i = 0; i < NR; i++) begin
        if (e_rspv[n][i]) begin
          n_tests++;
          if (rsp_p[n][i*16 +: 16] !== m_prod[n][i]) begin
            n_fail++; $display("FAIL rr_prod n=%0d slot=%0d got %h want %h", n, i, rsp_p[n][i*16 +: 16], m_prod[n][i]);
          end
        end
      end
      for (int i = 0; i < NR; i++) if (req_ready[n][i] === 1'b1) gl.push_back(i);
      tick();
    end
    n_tests++;
    if (gl.size() < 8) begin
      n_fail++; $display("FAIL rr_count n=%0d got %0d grants want >= 8", n, gl.size());
    end
    for (int j = 0; j < gl.size(); j++) begin
      n_tests++;
      if (gl[j] != j % NR) begin
        n_fail++; $display("FAIL rr_order n=%0d grant#%0d got %0d want %0d", n, j, gl[j], j % NR);
      end
    end
  endtask

  task automatic test_backpressure(input int n);
    int lat = lat_of(n);
    int hs  = lat + 2 + 10;
    do_reset();
    for (int c = 0; c <= hs + lat + 5; c++) begin
      req_a[n] = $urandom; req_b[n] = $urandom;
      req_a[n][23:16] = (c == 0) ? 8'd3 : 8'd4;
      req_b[n][23:16] = (c == 0) ? 8'd5 : 8'd6;
      req_valid[n] = 4'b0100;
      rsp_ready[n] = (c >= hs) ? 4'b1111 : 4'b1011;
      eval_all();
      @(negedge clk);
      n_tests++;
      if ({req_ready[n], rsp_valid[n], dp_valid[n], busy[n]} !== {e_rdy[n], e_rspv[n], m_dpv[n], e_busy[n]}) begin
        n_fail++;
        $display("FAIL bp_ctl n=%0d c=%0d got rdy=%b rspv=%b dpv=%b busy=%b want %b %b %b %b", n, c,
                 req_ready[n], rsp_valid[n], dp_valid[n], busy[n], e_rdy[n], e_rspv[n], m_dpv[n], e_busy[n]);
      end
      if (c >= lat + 2 && c <= hs) begin
        n_tests++;
        if (rsp_valid[n][2] !== 1'b1 || rsp_p[n][47:32] !== 16'd15) begin
          n_fail++; $display("FAIL bp_hold n=%0d c=%0d got v=%b p=%0d want 1 15", n, c, rsp_valid[n][2], rsp_p[n][47:32]);
        end
      end
      if (c >= 1 && c <= hs) begin
        n_tests++;
        if (req_ready[n][2] !== 1'b0) begin
          n_fail++; $display("FAIL bp_nogrant n=%0d c=%0d got %b want 0", n, c, req_ready[n][2]);
        end
      end
      if (c == hs + 1) begin
        n_tests++;
        if (req_ready[n][2] !== 1'b1) begin
          n_fail++; $display("FAIL bp_regrant n=%0d got %b want 1", n, req_ready[n][2]);
        end
      end
      if (c == hs + 1 + lat + 2) begin
        n_tests++;
        if (rsp_valid[n][2] !== 1'b1 || rsp_p[n][47:32] !== 16'd24) begin
          n_fail++; $display("FAIL bp_second n=%0d got v=%b p=%0d want 1 24", n, rsp_valid[n][2], rsp_p[n][47:32]);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back(input int n);
    int lat = lat_of(n);
    do_reset();
    // one grant to requester 1 moves the pointer to 2
    for (int c = 0; c <= lat + 3; c++) begin
      req_a[n] = $urandom; req_b[n] = $urandom;
      req_valid[n] = (c == 0) ? 4'b0010 : 4'b0000;
      rsp_ready[n] = 4'b1111;
      tick();
    end
    for (int d = 0; d <= lat + 5; d++) begin
      req_a[n] = $urandom; req_b[n] = $urandom;
      req_a[n][15:8] = 8'd7;   req_b[n][15:8] = 8'd9;
      req_a[n][31:24] = 8'd200; req_b[n][31:24] = 8'd2;
      req_valid[n] = (d == 0) ? 4'b1010 : ((d == 1) ? 4'b0010 : 4'b0000);
      rsp_ready[n] = 4'b1111;
      eval_all();
      @(negedge clk);
      n_tests++;
      if ({req_ready[n], rsp_valid[n], dp_valid[n], busy[n]} !== {e_rdy[n], e_rspv[n], m_dpv[n], e_busy[n]}) begin
        n_fail++;
        $display("FAIL b2b_ctl n=%0d d=%0d got rdy=%b rspv=%b dpv=%b busy=%b want %b %b %b %b", n, d,
                 req_ready[n], rsp_valid[n], dp_valid[n], busy[n], e_rdy[n], e_rspv[n], m_dpv[n], e_busy[n]);
      end
      if (d == 0 || d == 1) begin
        n_tests++;
        if (req_ready[n] !== ((d == 0) ? 4'b1000 : 4'b0010)) begin
          n_fail++; $display("FAIL b2b_grant n=%0d d=%0d got %b", n, d, req_ready[n]);
        end
      end
      if (d == lat + 2) begin
        n_tests++;
        if (rsp_valid[n] !== 4'b1000 || rsp_p[n][63:48] !== 16'd400) begin
          n_fail++; $display("FAIL b2b_rsp3 n=%0d got v=%b p=%0d want 1000 400", n, rsp_valid[n], rsp_p[n][63:48]);
        end
      end
      if (d == lat + 3) begin
        n_tests++;
        if (rsp_valid[n] !== 4'b0010 || rsp_p[n][31:16] !== 16'd63) begin
          n_fail++; $display("FAIL b2b_rsp1 n=%0d got v=%b p=%0d want 0010 63", n, rsp_valid[n], rsp_p[n][31:16]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight(input int n);
    int lat = lat_of(n);
    do_reset();
    req_a[n] = $urandom; req_b[n] = $urandom;
    req_valid[n] = 4'b0001; rsp_ready[n] = 4'b1111;
    tick();
    req_valid[n] = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dp_valid[n] !== 1'b0 || rsp_valid[n] !== 4'b0 || busy[n] !== 1'b0 || dp_a[n] !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset n=%0d got dpv=%b rspv=%b busy=%b a=%h want 0", n, dp_valid[n], rsp_valid[n], busy[n], dp_a[n]);
    end
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
    for (int c = 0; c <= lat + 4; c++) begin
      eval_all();
      @(negedge clk);
      n_tests++;
      if (rsp_valid[n] !== 4'b0 || busy[n] !== 1'b0 || dp_valid[n] !== 1'b0) begin
        n_fail++; $display("FAIL mid_quiet n=%0d c=%0d got rspv=%b busy=%b dpv=%b want 0", n, c, rsp_valid[n], busy[n], dp_valid[n]);
      end
      tick();
    end
    // pointer must be back at 0: requester 0 wins over 1
    req_valid[n] = 4'b0011;
    eval_all();
    @(negedge clk);
    n_tests++;
    if (req_ready[n] !== 4'b0001) begin
      n_fail++; $display("FAIL mid_ptr n=%0d got %b want 0001", n, req_ready[n]);
    end
    tick();
    req_valid[n] = 4'b0000;
    for (int c = 0; c <= lat + 3; c++) begin
      eval_all();
      @(negedge clk);
      n_tests++;
      if ({rsp_valid[n], busy[n]} !== {e_rspv[n], e_busy[n]}) begin
        n_fail++; $display("FAIL mid_new n=%0d c=%0d got rspv=%b busy=%b want %b %b", n, c, rsp_valid[n], busy[n], e_rspv[n], e_busy[n]);
      end
      tick();
    end
  endtask

  task automatic test_random(input int n);
    do_reset();
    for (int c = 0; c < 300; c++) begin
      req_valid[n] = 4'($urandom);
      rsp_ready[n] = 4'($urandom);
      req_a[n] = $urandom; req_b[n] = $urandom;
      eval_all();
      @(negedge clk);
      n_tests++;
      if ({req_ready[n], rsp_valid[n], dp_valid[n], busy[n]} !== {e_rdy[n], e_rspv[n], m_dpv[n], e_busy[n]}) begin
        n_fail++;
        $display("FAIL rnd_ctl n=%0d c=%0d got rdy=%b rspv=%b dpv=%b busy=%b want %b %b %b %b", n, c,
                 req_ready[n], rsp_valid[n], dp_valid[n], busy[n], e_rdy[n], e_rspv[n], m_dpv[n], e_busy[n]);
      end
      n_tests++;
      if (dp_a[n] !== m_dpa[n] || dp_b[n] !== m_dpb[n]) begin
        n_fail++; $display("FAIL rnd_dp n=%0d c=%0d got %h %h want %h %h", n, c, dp_a[n], dp_b[n], m_dpa[n], m_dpb[n]);
      end
      for (int i = 0; i < NR; i++) begin
        if (e_rspv[n][i]) begin
          n_tests++;
          if (rsp_p[n][i*16 +: 16] !== m_prod[n][i]) begin
            n_fail++; $display("FAIL rnd_prod n=%0d c=%0d slot=%0d got %h want %h", n, c, i, rsp_p[n][i*16 +: 16], m_prod[n][i]);
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    for (int n = 0; n < NI; n++) begin
      test_single(n);
      test_back_to_back(n);
    end
    test_rr(0);
    test_rr(1);
    test_backpressure(0);
    test_backpressure(2);
    test_reset_midflight(0);
    test_reset_midflight(2);
    for (int n = 0; n < NI; n++) test_random(n);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
